// File: rtl/noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// noc_output_arbiter
//
// Purpose:
//   Round-robin, packet-locked (wormhole) arbiter that shares one router
//   output link among N_PORTS input FIFOs. Once a port wins, it keeps the
//   link until PKT_LEN flits have been read from it. The flits go to the
//   downstream FIFO's write port, and the arbiter respects that FIFO's
//   full/almost-full backpressure.
//
// Parameters:
//   N_PORTS  number of requesting input FIFOs
//   DATA_W   flit width
//   PKT_LEN  flits per packet (>= 1); the grant is held for exactly this many reads
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   in_empty   per-port empty flag of the input FIFOs
//   in_data    per-port FIFO Data_out, port i at [i*DATA_W +: DATA_W]
//   rd         per-port read strobe, at most one bit high, forced 0 in reset
//   out_full   downstream FIFO full
//   out_afull  downstream FIFO has at most one free slot
//   out_data   flit to the downstream FIFO (0 when out_valid is low)
//   out_valid  write strobe to the downstream FIFO, one cycle after rd
//   grant      registered one-hot owner of the link, 0 when idle
//   busy       high while a packet owns the link
// ---------------------------------------------------------------------------
module noc_output_arbiter #(
    parameter int N_PORTS = 5,
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          in_empty,
    input  logic [N_PORTS*DATA_W-1:0]   in_data,
    output logic [N_PORTS-1:0]          rd,
    input  logic                        out_full,
    input  logic                        out_afull,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic [N_PORTS-1:0]          grant,
    output logic                        busy
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = $clog2(PKT_LEN) + 1;

    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PKT_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_PORTS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // (base + off) mod N_PORTS, where both operands are already below N_PORTS.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int              off);
        int s;
        s = int'(base) + off;
        if (s >= N_PORTS) begin
            s = s - N_PORTS;
        end
        return PTR_W'(s);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]     owner_q,     owner_d;
    logic [PTR_W-1:0]     src_sel_q,   src_sel_d;
    logic [CNT_W-1:0]     flit_cnt_q,  flit_cnt_d;
    logic [N_PORTS-1:0]   grant_q,     grant_d;
    logic                 busy_q,      busy_d;
    logic                 out_valid_q, out_valid_d;

    // -----------------------------------------------------------------------
    // Per-port views of the packed input buses
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]    port_data [N_PORTS];
    logic [N_PORTS-1:0]   req;

    // Candidate k is the port at distance k from the round-robin pointer.
    // The lowest k that is requesting wins.
    logic [PTR_W-1:0]     cand_idx  [N_PORTS];
    logic [N_PORTS-1:0]   cand_hit;

    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [N_PORTS-1:0]   pick_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign port_data[gi]   = in_data[gi*DATA_W +: DATA_W];
            assign req[gi]         = ~in_empty[gi];
            assign cand_idx[gi]    = wrap_add(rr_ptr_q, gi);
            assign cand_hit[gi]    = req[cand_idx[gi]];
            assign pick_onehot[gi] = (pick_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        // Scan from the farthest candidate down, so the nearest hit is the
        // last assignment and takes effect.
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read strobe
    // -----------------------------------------------------------------------
    // out_full lags a write that is already in flight by one cycle. If the
    // downstream FIFO has one free slot and a write is landing this cycle,
    // another read could overflow it, so the read is held off.
    logic owner_ready;
    logic rd_fire;

    assign owner_ready = ~in_empty[owner_q] & ~out_full & ~(out_afull & out_valid_q);
    assign rd_fire     = rst & (state_q == S_BUSY) & owner_ready;

    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_rd
            assign rd[gi] = rd_fire & (owner_q == PTR_W'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        src_sel_d   = src_sel_q;
        flit_cnt_d  = flit_cnt_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        out_valid_d = rd_fire;

        case (state_q)
            S_IDLE: begin
                // No read is issued while idle. The winner is only registered
                // here, and its first flit is read on the next cycle.
                if (pick_found) begin
                    state_d    = S_BUSY;
                    owner_d    = pick_idx;
                    grant_d    = pick_onehot;
                    busy_d     = 1'b1;
                    flit_cnt_d = '0;
                end
            end

            S_BUSY: begin
                // An empty owner simply stalls. The link stays locked to the
                // owner until the whole packet has been read.
                if (rd_fire) begin
                    src_sel_d = owner_q;
                    if (flit_cnt_q == LAST_FLIT) begin
                        state_d    = S_IDLE;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                        flit_cnt_d = '0;
                        // The port that just finished gets the lowest priority next.
                        rr_ptr_d   = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
                    end else begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            src_sel_q   <= '0;
            flit_cnt_q  <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            src_sel_q   <= src_sel_d;
            flit_cnt_q  <= flit_cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The source FIFO updates Data_out on the edge that consumed the read,
    // so the flit is already on its Data_out when out_valid rises.
    assign out_data  = out_valid_q ? port_data[src_sel_q] : '0;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_output_arbiter
//
// The bench drives noc_output_arbiter from a behavioural model of the input
// FIFOs, which are queues whose Data_out advances on a read. A reference
// model built from the arbitration rules predicts rd, grant, busy, out_valid
// and out_data for every cycle. The run starts with directed scenarios and
// ends with a randomized phase of packet arrivals and backpressure.
// ---------------------------------------------------------------------------
module tb_noc_output_arbiter;

    localparam int N = 5;
    localparam int W = 8;
    localparam int L = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [N-1:0]       in_empty;
    logic [N*W-1:0]     in_data;
    logic [N-1:0]       rd;
    logic               out_full  = 1'b0;
    logic               out_afull = 1'b0;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic [N-1:0]       grant;
    logic               busy;

    always #5 clk = ~clk;

    noc_output_arbiter #(
        .N_PORTS (N),
        .DATA_W  (W),
        .PKT_LEN (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .rd        (rd),
        .out_full  (out_full),
        .out_afull (out_afull),
        .out_data  (out_data),
        .out_valid (out_valid),
        .grant     (grant),
        .busy      (busy)
    );

    // Input FIFO environment
    typedef logic [W-1:0] flit_q_t [$];
    flit_q_t      q [N];
    logic [W-1:0] dout [N];

    // Reference model state: the owner is -1 when the link is idle
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_ptr   = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_last  = '0;

    int passed = 0;
    int total  = 0;

    logic [N-1:0] prev_grant = '0;
    int           dut_order [$];
    logic [W-1:0] out_log   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_fifo_outputs();
        for (int i = 0; i < N; i++) begin
            in_empty[i]       = (q[i].size() == 0);
            in_data[i*W +: W] = dout[i];
        end
    endtask

    task automatic push_pkt(input int port, input logic [W-1:0] base);
        for (int j = 0; j < L; j++) q[port].push_back(W'(base + W'(j)));
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (q[i].size() != 0) r = 1'b1;
        return r;
    endfunction

    // One clock cycle. Compare the DUT with the model, let the edge happen,
    // then advance the model and the FIFOs.
    task automatic cycle();
        logic [N-1:0] exp_rd;
        logic [N-1:0] exp_grant;
        logic [N-1:0] rd_seen;
        logic [W-1:0] next_last;
        drive_fifo_outputs();
        #1;
        exp_rd    = '0;
        exp_grant = '0;
        next_last = m_last;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        if (rst && m_owner >= 0 && q[m_owner].size() != 0 && !out_full && !(out_afull && m_valid)) begin
            exp_rd[m_owner] = 1'b1;
            next_last       = q[m_owner][0];
        end
        check("rd", 32'(rd), 32'(exp_rd));
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), m_valid ? 32'(m_last) : 32'd0);
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < N; i++) if (grant[i]) dut_order.push_back(i);
        prev_grant = grant;
        if (out_valid) out_log.push_back(out_data);
        rd_seen = rd;

        @(posedge clk);
        #1;
        // Model update
        if (!rst) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0; m_valid = 1'b0;
        end else if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (m_owner < 0 && q[p].size() != 0) begin
                    m_owner = p;
                    m_cnt   = 0;
                end
            end
        end else begin
            m_valid = (exp_rd != '0);
            if (m_valid) begin
                m_last = next_last;
                m_cnt++;
                if (m_cnt == L) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
        // FIFO environment reacts to the DUT's actual read strobes
        for (int i = 0; i < N; i++)
            if (rd_seen[i] && q[i].size() != 0) dout[i] = q[i].pop_front();
    endtask

    task automatic run_until_cnt2(input string tag);
        int n = 0;
        while (!(m_owner >= 0 && m_cnt == 2) && n < 50) begin
            cycle();
            n++;
        end
        check(tag, 32'(m_owner >= 0 && m_cnt == 2), 32'd1);
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((any_pending() || m_owner >= 0 || m_valid) && n < limit) begin
            cycle();
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    task automatic check_log(input string tag, input logic [W-1:0] base);
        for (int j = 0; j < L; j++) begin
            logic [W-1:0] v;
            v = (j < out_log.size()) ? out_log[j] : 'x;
            check(tag, 32'(v), 32'(W'(base + W'(j))));
        end
    endtask

    task automatic check_order(input string tag, input int idx, input int exp);
        int v;
        v = (idx < dut_order.size()) ? dut_order[idx] : -1;
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < N; i++) dout[i] = '0;
        drive_fifo_outputs();
        @(posedge clk);
        #1;

        // Reset held with every port loaded, then drain five packets
        for (int p = 0; p < N; p++) push_pkt(p, W'(8'h10 * (p + 1)));
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("grant_after_release", 32'(grant), 32'h01);
        drain("drain_reset_all", 400);

        // Single requester on port 2 with flits 1..4
        out_log.delete();
        push_pkt(2, 8'h01);
        drain("drain_single", 100);
        check("single_len", 32'(out_log.size()), 32'(L));
        check_log("single_flit", 8'h01);

        // Round robin from pointer 0: ports 0, 1 and 4, with two packets on port 0
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        dut_order.delete();
        push_pkt(0, 8'h60);
        push_pkt(0, 8'h70);
        push_pkt(1, 8'h80);
        push_pkt(4, 8'h90);
        drain("drain_rr", 200);
        check_order("rr_order0", 0, 0);
        check_order("rr_order1", 1, 1);
        check_order("rr_order2", 2, 4);
        check_order("rr_order3", 3, 0);

        // Backpressure: full for 3 cycles after 2 flits, then afull while a write is in flight
        out_log.delete();
        push_pkt(2, 8'hA0);
        run_until_cnt2("bp_reach");
        out_full = 1'b1;
        repeat (3) cycle();
        out_full = 1'b0;
        cycle();
        out_afull = 1'b1;
        cycle();
        out_afull = 1'b0;
        drain("drain_bp", 100);
        check_log("bp_flit", 8'hA0);

        // Mid-packet starvation: owner port 3 runs dry after 2 flits while port 0 waits
        out_log.delete();
        q[3].push_back(8'hC0);
        q[3].push_back(8'hC1);
        run_until_cnt2("starve_reach");
        push_pkt(0, 8'hD0);
        repeat (4) cycle();
        check("starve_grant", 32'(grant), 32'h08);
        check("starve_rd0", 32'(rd[0]), 32'd0);
        q[3].push_back(8'hC2);
        q[3].push_back(8'hC3);
        drain("drain_starve", 100);
        check_log("starve_flit", 8'hC0);

        // Reset mid-packet on port 1; arbitration restarts from port 0
        push_pkt(1, 8'hE0);
        push_pkt(3, 8'hF0);
        run_until_cnt2("mid_reset_reach");
        rst = 1'b0;
        cycle();
        check("mid_reset_grant", 32'(grant), 32'd0);
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        dut_order.delete();
        q[1].push_back(8'hE8);
        q[1].push_back(8'hE9);
        drain("drain_mid_reset", 100);
        check_order("mid_reset_order0", 0, 1);
        check_order("mid_reset_order1", 1, 3);

        // Randomized packet arrivals and backpressure
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                int p;
                p = int'($urandom_range(0, N - 1));
                if (q[p].size() < 12) push_pkt(p, W'($urandom));
            end
            out_full  = ($urandom_range(0, 4) == 0);
            out_afull = ($urandom_range(0, 3) == 0);
            cycle();
        end
        out_full  = 1'b0;
        out_afull = 1'b0;
        drain("drain_random", 2000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
